// File: rtl/sample_group_unpacker_pkg.sv
// Shared types and helpers for the sample group unpacker.
//   grp_hdr_t      : packet header layout {gid, cnt, seq}
//   unpack_state_e : FSM state encoding
//   words_for()    : stream words needed to carry a vector of a given width
package sample_unpack_pkg;

  localparam int HDR_W = 32;
  localparam int SEQ_W = 16;

  typedef struct packed {
    logic [7:0]       gid;
    logic [7:0]       cnt;
    logic [SEQ_W-1:0] seq;
  } grp_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_CSUM    = 3'd2,
    ST_DROP    = 3'd3,
    ST_COMMIT  = 3'd4
  } unpack_state_e;

  function automatic int words_for(input int width);
    return (width + HDR_W - 1) / HDR_W;
  endfunction

endpackage

// File: rtl/sample_group_unpacker_if.sv
// Word stream carrying group packets from the host-fed FIFO.
//   in_valid : word valid (master -> slave)
//   in_data  : stream word (master -> slave)
//   in_ready : slave accepts word; transfer when in_valid & in_ready
interface sample_group_unpacker_if
  import sample_unpack_pkg::*;
#(
  parameter int DATA_W = HDR_W
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/sample_group_unpacker_regbank.sv
// Per-group output registers for the unpacker.
// Holds the NUM_GROUPS x GROUP_W signal vectors and the expected sequence
// number of every group. A commit strobe plus group id writes one slice,
// raises that group's update bit for one cycle and flags a sequence mismatch.
//   clock, reset : rising-edge clock, async active-low reset
//   commit       : one-cycle write strobe
//   gid, seq     : group id and sequence number of the committed packet
//   data         : reassembled group vector
//   grp_data     : all group vectors, group g at [g*GROUP_W +: GROUP_W]
//   grp_update   : one-cycle pulse per committed group
//   err_seq      : one-cycle pulse, committed seq differed from expected
module sample_group_regbank
  import sample_unpack_pkg::*;
#(
  parameter int NUM_GROUPS = 4,
  parameter int GROUP_W    = 128
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          commit,
  input  logic [7:0]                    gid,
  input  logic [SEQ_W-1:0]              seq,
  input  logic [GROUP_W-1:0]            data,
  output logic [NUM_GROUPS*GROUP_W-1:0] grp_data,
  output logic [NUM_GROUPS-1:0]         grp_update,
  output logic                          err_seq
);

  logic [NUM_GROUPS*GROUP_W-1:0]       grp_data_q, grp_data_d;
  logic [NUM_GROUPS-1:0][SEQ_W-1:0]    exp_seq_q, exp_seq_d;
  logic [NUM_GROUPS-1:0]               upd_q, upd_d;
  logic                                err_seq_q, err_seq_d;

  always_comb begin
    grp_data_d = grp_data_q;
    exp_seq_d  = exp_seq_q;
    upd_d      = '0;
    err_seq_d  = 1'b0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (commit && (gid == 8'(g))) begin
        grp_data_d[g*GROUP_W +: GROUP_W] = data;
        upd_d[g]     = 1'b1;
        err_seq_d    = (seq != exp_seq_q[g]);
        // 16-bit wrap: 0xFFFF is followed by 0x0000
        exp_seq_d[g] = seq + SEQ_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grp_data_q <= '0;
      exp_seq_q  <= '0;
      upd_q      <= '0;
      err_seq_q  <= 1'b0;
    end else begin
      grp_data_q <= grp_data_d;
      exp_seq_q  <= exp_seq_d;
      upd_q      <= upd_d;
      err_seq_q  <= err_seq_d;
    end
  end

  assign grp_data   = grp_data_q;
  assign grp_update = upd_q;
  assign err_seq    = err_seq_q;

endmodule

// File: rtl/sample_group_unpacker.sv
// Receiving end of the sampled-signal group export path.
// Parses a 32-bit word stream of {header, payload} packets, rebuilds each
// group's signal vector and commits it to the register bank.
// Optional feature macro: SAMPLE_UNPACK_CHECKSUM_EN -- when defined every
// packet carries a trailing XOR checksum word checked in state CSUM.
//   clock, reset : rising-edge clock, async active-low reset
//   in_if        : slave side of the word stream (valid/data/ready)
//   grp_data     : group vectors, group g at [g*GROUP_W +: GROUP_W]
//   grp_update   : one-cycle pulse, bit g set when group g is committed
//   err_len      : pulse, header word count differs from WORDS
//   err_id       : pulse, header group id out of range
//   err_seq      : pulse, sequence mismatch (packet still committed)
//   err_csum     : pulse, checksum mismatch (tied 0 without the feature)
//
// state   | meaning
// IDLE    | waiting for a header word
// PAYLOAD | collecting WORDS payload words into staging
// CSUM    | comparing the trailing checksum word (feature only)
// DROP    | discarding the payload of a rejected header
// COMMIT  | one cycle, in_ready low, staging written to the register bank
module sample_group_unpacker
  import sample_unpack_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_GROUPS = 4,
  parameter int GROUP_W    = 128
) (
  input  logic                          clock,
  input  logic                          reset,
  sample_group_unpacker_if.slave        in_if,
  output logic [NUM_GROUPS*GROUP_W-1:0] grp_data,
  output logic [NUM_GROUPS-1:0]         grp_update,
  output logic                          err_len,
  output logic                          err_id,
  output logic                          err_seq,
  output logic                          err_csum
);

  localparam int WORDS = words_for(GROUP_W);
  localparam int STG_W = WORDS * DATA_W;

  localparam logic [7:0] NUM_GROUPS_B = 8'(NUM_GROUPS);
  localparam logic [7:0] WORDS_B      = 8'(WORDS);
  localparam logic [7:0] LAST_IDX     = 8'(WORDS - 1);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_PAYLOAD = ST_PAYLOAD;
  localparam logic [2:0] S_DROP    = ST_DROP;
  localparam logic [2:0] S_COMMIT  = ST_COMMIT;
`ifdef SAMPLE_UNPACK_CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = ST_CSUM;
`endif

  logic [2:0]       state_q, state_d;
  logic [7:0]       gid_q, gid_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       rem_q, rem_d;
  logic [STG_W-1:0] staging_q, staging_d;
  logic             err_len_q, err_len_d;
  logic             err_id_q, err_id_d;
`ifdef SAMPLE_UNPACK_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              err_csum_q, err_csum_d;
`endif

  grp_hdr_t hdr_in;
  logic     hs;
  logic     bad_id;
  logic     bad_len;
  logic     commit;

  assign in_if.in_ready = (state_q != S_COMMIT);
  assign hs             = in_if.in_valid & in_if.in_ready;
  assign hdr_in         = grp_hdr_t'(in_if.in_data);
  assign bad_id         = (hdr_in.gid >= NUM_GROUPS_B);
  assign bad_len        = (hdr_in.cnt != WORDS_B);

  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    seq_d     = seq_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    staging_d = staging_q;
    err_len_d = 1'b0;
    err_id_d  = 1'b0;
    commit    = 1'b0;
`ifdef SAMPLE_UNPACK_CHECKSUM_EN
    csum_d     = csum_q;
    err_csum_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          err_id_d  = bad_id;
          err_len_d = bad_len;
          if (bad_id || bad_len) begin
            // a zero-count bad header has nothing to skip
            if (hdr_in.cnt != 8'd0) begin
              state_d = S_DROP;
              rem_d   = hdr_in.cnt;
            end
          end else begin
            state_d = S_PAYLOAD;
            idx_d   = 8'd0;
            gid_d   = hdr_in.gid;
            seq_d   = hdr_in.seq;
`ifdef SAMPLE_UNPACK_CHECKSUM_EN
            csum_d  = in_if.in_data;
`endif
          end
        end
      end
      S_PAYLOAD: begin
        if (hs) begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx_q == 8'(w)) staging_d[w*DATA_W +: DATA_W] = in_if.in_data;
          end
`ifdef SAMPLE_UNPACK_CHECKSUM_EN
          csum_d = csum_q ^ in_if.in_data;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef SAMPLE_UNPACK_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_COMMIT;
`endif
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
`ifdef SAMPLE_UNPACK_CHECKSUM_EN
      S_CSUM: begin
        if (hs) begin
          if (in_if.in_data == csum_q) begin
            state_d = S_COMMIT;
          end else begin
            err_csum_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
`endif
      S_DROP: begin
        if (hs) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gid_q     <= '0;
      seq_q     <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      staging_q <= '0;
      err_len_q <= 1'b0;
      err_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gid_q     <= gid_d;
      seq_q     <= seq_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      staging_q <= staging_d;
      err_len_q <= err_len_d;
      err_id_q  <= err_id_d;
    end
  end

`ifdef SAMPLE_UNPACK_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum_q     <= '0;
      err_csum_q <= 1'b0;
    end else begin
      csum_q     <= csum_d;
      err_csum_q <= err_csum_d;
    end
  end
  assign err_csum = err_csum_q;
`else
  assign err_csum = 1'b0;
`endif

  assign err_len = err_len_q;
  assign err_id  = err_id_q;

  // bits of staging above GROUP_W never reach the outputs
  sample_group_regbank #(
    .NUM_GROUPS (NUM_GROUPS),
    .GROUP_W    (GROUP_W)
  ) u_regbank (
    .clock      (clock),
    .reset      (reset),
    .commit     (commit),
    .gid        (gid_q),
    .seq        (seq_q),
    .data       (staging_q[GROUP_W-1:0]),
    .grp_data   (grp_data),
    .grp_update (grp_update),
    .err_seq    (err_seq)
  );

endmodule

// File: tb/tb_sample_group_unpacker.sv
module tb_sample_group_unpacker;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [511:0] grp_data;
  logic [3:0]   grp_update;
  logic         err_len, err_id, err_seq, err_csum;

  sample_group_unpacker_if #(.DATA_W(32)) in_if ();

  sample_group_unpacker #(
    .DATA_W(32), .NUM_GROUPS(4), .GROUP_W(128)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_if      (in_if),
    .grp_data   (grp_data),
    .grp_update (grp_update),
    .err_len    (err_len),
    .err_id     (err_id),
    .err_seq    (err_seq),
    .err_csum   (err_csum)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // stimulus stream and reference model state
  logic [31:0]  stream[$];
  logic [31:0]  pay[$];
  logic [127:0] m_data[4];
  logic [15:0]  m_seq[4];

  logic [3:0]   exp_upd[$];
  logic [127:0] exp_data[$];
  logic         exp_seqerr[$];
  int           exp_id, exp_len, exp_csum;

  logic [3:0]   obs_upd[$];
  logic [127:0] obs_data[$];
  logic         obs_seqerr[$];
  int           obs_id, obs_len, obs_csum, obs_rdy_low, obs_stray_seq;
  logic [127:0] mon_sl;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (grp_update != 4'b0) begin
        mon_sl = '0;
        for (int g = 3; g >= 0; g--) if (grp_update[g]) mon_sl = grp_data[g*128 +: 128];
        obs_upd.push_back(grp_update);
        obs_data.push_back(mon_sl);
        obs_seqerr.push_back(err_seq);
      end else if (err_seq) begin
        obs_stray_seq++;
      end
      if (err_id)    obs_id++;
      if (err_len)   obs_len++;
      if (err_csum)  obs_csum++;
      if (!in_if.in_ready) obs_rdy_low++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // appends header + cnt payload words (+ checksum for well-formed packets)
  task automatic add_pkt(input int gid, input int cnt, input int seq, input bit corrupt);
    logic [31:0] h, w, x;
    h = {8'(gid), 8'(cnt), 16'(seq)};
    stream.push_back(h);
    x = h;
    for (int k = 0; k < cnt; k++) begin
      if (pay.size() > 0) w = pay.pop_front();
      else                w = $urandom;
      stream.push_back(w);
      x = x ^ w;
    end
`ifdef SAMPLE_UNPACK_CHECKSUM_EN
    if (gid < 4 && cnt == 4) stream.push_back(corrupt ? (x ^ 32'h0000_0100) : x);
`else
    if (corrupt) x = '0;
`endif
  endtask

  // reference: walk the packet stream using the protocol rules
  task automatic model_stream();
    int i;
    logic [31:0]  h, x;
    logic [127:0] pl;
    int gid, cnt;
    logic [15:0] sq;
    bit ok;
    i = 0;
    while (i < stream.size()) begin
      h = stream[i]; i++;
      gid = int'(h[31:24]); cnt = int'(h[23:16]); sq = h[15:0];
      if (gid >= 4 || cnt != 4) begin
        if (gid >= 4) exp_id++;
        if (cnt != 4) exp_len++;
        i += cnt;
      end else begin
        pl = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
        x  = h ^ stream[i] ^ stream[i+1] ^ stream[i+2] ^ stream[i+3];
        i += 4;
        ok = 1'b1;
`ifdef SAMPLE_UNPACK_CHECKSUM_EN
        if (stream[i] != x) begin ok = 1'b0; exp_csum++; end
        i++;
`endif
        if (ok) begin
          exp_upd.push_back(4'b0001 << gid);
          exp_data.push_back(pl);
          exp_seqerr.push_back(sq != m_seq[gid]);
          m_seq[gid]  = sq + 16'd1;
          m_data[gid] = pl;
        end
      end
    end
  endtask

  // called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge
  task automatic send_word(input logic [31:0] w, input int gap);
    int guard;
    in_if.in_valid = 1'b0;
    repeat (gap) @(negedge clock);
    in_if.in_valid = 1'b1;
    in_if.in_data  = w;
    guard = 0;
    while (!in_if.in_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++; n_fail++;
      $error("FAIL ready_timeout: observed in_ready low for %0d cycles expected at most 19", guard);
    end
    @(negedge clock);
    in_if.in_valid = 1'b0;
  endtask

  task automatic clear_obs();
    obs_upd.delete(); obs_data.delete(); obs_seqerr.delete();
    obs_id = 0; obs_len = 0; obs_csum = 0; obs_rdy_low = 0; obs_stray_seq = 0;
    exp_upd.delete(); exp_data.delete(); exp_seqerr.delete();
    exp_id = 0; exp_len = 0; exp_csum = 0;
  endtask

  task automatic check_phase(input string tag);
    int n;
    logic [511:0] exp_all;
    check_val({tag, "_commits"}, 512'(obs_upd.size()), 512'(exp_upd.size()));
    n = (obs_upd.size() < exp_upd.size()) ? obs_upd.size() : exp_upd.size();
    for (int k = 0; k < n; k++) begin
      check_val($sformatf("%s_upd%0d", tag, k), 512'(obs_upd[k]), 512'(exp_upd[k]));
      check_val($sformatf("%s_data%0d", tag, k), 512'(obs_data[k]), 512'(exp_data[k]));
      check_val($sformatf("%s_seqerr%0d", tag, k), 512'(obs_seqerr[k]), 512'(exp_seqerr[k]));
    end
    check_val({tag, "_err_id"}, 512'(obs_id), 512'(exp_id));
    check_val({tag, "_err_len"}, 512'(obs_len), 512'(exp_len));
    check_val({tag, "_err_csum"}, 512'(obs_csum), 512'(exp_csum));
    check_val({tag, "_stray_seq"}, 512'(obs_stray_seq), 512'(0));
    check_val({tag, "_ready_low"}, 512'(obs_rdy_low), 512'(exp_upd.size()));
    for (int g = 0; g < 4; g++) exp_all[g*128 +: 128] = m_data[g];
    check_val({tag, "_grp_data"}, grp_data, exp_all);
    clear_obs();
  endtask

  task automatic run_stream(input string tag, input int max_gap);
    model_stream();
    foreach (stream[k]) send_word(stream[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    repeat (4) @(negedge clock);
    stream.delete();
    check_phase(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_grp_data"}, grp_data, '0);
    check_val({tag, "_outs"}, 512'({grp_update, err_len, err_id, err_seq, err_csum, in_if.in_ready}),
              512'({4'b0, 4'b0, 1'b1}));
  endtask

  logic [31:0] saved[$];

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    for (int g = 0; g < 4; g++) begin m_data[g] = '0; m_seq[g] = '0; end
    clear_obs();

    // reset state
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("after_reset");

    // single packet with explicit timing checks
    pay = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    add_pkt(1, 4, 0, 1'b0);
    model_stream();
    foreach (stream[k]) send_word(stream[k], 0);
    check_val("single_commit_ready_low", 512'(in_if.in_ready), 512'(0));
    check_val("single_upd_not_early", 512'(grp_update), 512'(0));
    @(negedge clock);
    check_val("single_upd", 512'(grp_update), 512'(4'b0010));
    check_val("single_slice", 512'(grp_data[255:128]),
              512'(128'h44444444_33333333_22222222_11111111));
    check_val("single_errs", 512'({err_len, err_id, err_seq, err_csum}), 512'(0));
    check_val("single_ready_back", 512'(in_if.in_ready), 512'(1));
    @(negedge clock);
    check_val("single_upd_one_cycle", 512'(grp_update), 512'(0));
    repeat (2) @(negedge clock);
    stream.delete();
    check_phase("single");

    // bad id, dropped payload, then a good packet
    add_pkt(7, 4, 0, 1'b0);
    add_pkt(2, 4, 0, 1'b0);
    run_stream("bad_id", 0);

    // bad length with drop, zero length without drop, then a good packet
    add_pkt(1, 2, 1, 1'b0);
    add_pkt(2, 0, 1, 1'b0);
    add_pkt(3, 4, 0, 1'b0);
    run_stream("bad_len", 0);

    // sequence tracking and 16-bit wrap
    add_pkt(0, 4, 0, 1'b0);
    add_pkt(0, 4, 5, 1'b0);
    add_pkt(0, 4, 6, 1'b0);
    add_pkt(2, 4, 16'hFFFF, 1'b0);
    add_pkt(2, 4, 16'h0000, 1'b0);
    run_stream("seq", 0);

    // backpressure: same three packets with random gaps, then gap-free
    for (int p = 0; p < 3; p++) add_pkt(int'($urandom_range(0, 3)), 4, int'($urandom_range(0, 2)), 1'b0);
    saved = stream;
    run_stream("gaps", 3);
    stream = saved;
    run_stream("no_gaps", 0);

    // reset in the middle of a packet
    stream.delete();
    add_pkt(3, 4, 9, 1'b0);
    for (int k = 0; k < 3; k++) send_word(stream[k], 0);
    stream.delete();
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid_reset");
    for (int g = 0; g < 4; g++) begin m_data[g] = '0; m_seq[g] = '0; end
    clear_obs();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    add_pkt(3, 4, 0, 1'b0);
    run_stream("post_reset", 0);

`ifdef SAMPLE_UNPACK_CHECKSUM_EN
    add_pkt(1, 4, int'(m_seq[1]), 1'b1);
    add_pkt(1, 4, int'(m_seq[1]), 1'b0);
    run_stream("csum", 0);
`endif

    // random mix of good and bad packets with gaps
    for (int p = 0; p < 24; p++) begin
      int gid, cnt;
      gid = int'($urandom_range(0, 5));
      if (gid > 3) gid = 4 + int'($urandom_range(0, 251));
      cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 4;
      add_pkt(gid, cnt, int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
    end
    run_stream("random", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
